seq_divider: RTL and testbench

Multi-cycle restoring divider for the 8-bit ALU. It is the inverse-direction arithmetic unit to the synchronous add/sub block and uses the same operand naming (x, y, mode) and the same `done` completion convention. It computes quotient and remainder, one quotient bit per clock. The ALU top muxes its results onto the shared result bus when `done` pulses.

---
 rtl/alu_pkg.sv | 15 +
 rtl/twos_neg.sv | 14 +
 rtl/seq_divider.sv | 177 +++++++++++++++++
 tb/tb_seq_divider.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU arithmetic blocks (add/sub, divider, ALU top).
package alu_pkg;

  localparam int WIDTH = 8;

  // Controller state encoding, kept as plain constants so older blocks can share it
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  // Operand interpretation selected by the mode input
  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

endpackage

// File: rtl/twos_neg.sv
// Conditional two's-complement negate: out = en ? -in : in.
// Used for operand magnitude and for the quotient/remainder sign fix-up.
module twos_neg #(
  parameter int WIDTH = 8
) (
  input  logic             en_i,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  // Pure combinational negate; the most-negative value maps onto itself
  assign out_o = en_i ? (WIDTH'(0) - in_i) : in_i;

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Produces quotient, remainder and a divide-by-zero flag, all registered,
// with a one-cycle done pulse when they update.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start
// ST_RUN  | WIDTH restoring steps, then one finishing edge (sign fix-up)
// ST_FIN  | done pulse cycle; start here is accepted back-to-back
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude; zero marks divide-by-zero
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] x_abs, y_abs;
  logic [WIDTH-1:0] quot_fix, rem_fix;
  logic [WIDTH:0]   shifted, trial;

  twos_neg #(.WIDTH(WIDTH)) u_abs_x (
    .en_i (mode == MODE_SIGNED && x[WIDTH-1]),
    .in_i (x),
    .out_o(x_abs)
  );

  twos_neg #(.WIDTH(WIDTH)) u_abs_y (
    .en_i (mode == MODE_SIGNED && y[WIDTH-1]),
    .in_i (y),
    .out_o(y_abs)
  );

  twos_neg #(.WIDTH(WIDTH)) u_fix_q (
    .en_i (negq_q),
    .in_i (dvd_q),
    .out_o(quot_fix)
  );

  twos_neg #(.WIDTH(WIDTH)) u_fix_r (
    .en_i (negr_q),
    .in_i (prem_q),
    .out_o(rem_fix)
  );

  // One restoring step: shift in the next dividend bit and try to subtract the divisor
  assign shifted = {prem_q, dvd_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  // Next-state logic for the controller and datapath
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          // Divide-by-zero skips the steps (cnt=0) but still spends one RUN
          // cycle, so its done pulse lands one edge after acceptance.
          state_d = ST_RUN;
          prem_d  = '0;
          if (y == '0) begin
            cnt_d  = '0;
            dvd_d  = x;
            dvs_d  = '0;
            negq_d = 1'b0;
            negr_d = 1'b0;
          end else begin
            cnt_d  = CW'(WIDTH);
            dvd_d  = x_abs;
            dvs_d  = y_abs;
            negq_d = (mode == MODE_SIGNED) && (x[WIDTH-1] ^ y[WIDTH-1]);
            negr_d = (mode == MODE_SIGNED) && x[WIDTH-1];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
          if (!trial[WIDTH]) begin
            prem_d = trial[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            prem_d = shifted[WIDTH-1:0];
            dvd_d  = {dvd_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          state_d = ST_FIN;
          done_d  = 1'b1;
          if (dvs_q == '0) begin
            quot_d = '1;
            rem_d  = dvd_q;
            dz_d   = 1'b1;
          end else begin
            quot_d = quot_fix;
            rem_d  = rem_fix;
            dz_d   = 1'b0;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset that aborts any operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider with a completion scoreboard.
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] x, y;
  logic       mode;
  logic       busy, done, dz;
  logic [7:0] quot, rem;

  seq_divider #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .x    (x),
    .y    (y),
    .mode (mode),
    .busy (busy),
    .done (done),
    .quot (quot),
    .rem  (rem),
    .dz   (dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic m);
    exp_t e;
    int sa, sbv, qi, ri;
    e.due = 0;
    if (b == 8'd0) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else if (m) begin
      sa  = int'($signed(a));
      sbv = int'($signed(b));
      qi  = sa / sbv;
      ri  = sa % sbv;
      e.q = qi[7:0]; e.r = ri[7:0]; e.dz = 1'b0;
    end else begin
      qi  = int'(a) / int'(b);
      ri  = int'(a) % int'(b);
      e.q = qi[7:0]; e.r = ri[7:0]; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Pulse start for one cycle and record the expected completion cycle
  task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic m, input exp_t e);
    x = a; y = b; mode = m; start = 1'b1;
    e.due = cyc + 1 + ((b == 8'd0) ? 1 : 9);
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic launch_exp(input logic [7:0] a, input logic [7:0] b, input logic m,
                            input logic [7:0] eq, input logic [7:0] er, input logic ed);
    exp_t e;
    e.q = eq; e.r = er; e.dz = ed; e.due = 0;
    launch(a, b, m, e);
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask

  // Completion monitor: every done pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("latency", cyc, mon_e.due);
        chk("quot", 32'(quot), 32'(mon_e.q));
        chk("rem", 32'(rem), 32'(mon_e.r));
        chk("dz", 32'(dz), 32'(mon_e.dz));
        chk("busy_at_done", 32'(busy), 0);
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    logic       rm;

    rst = 1'b1; start = 1'b0; x = '0; y = '0; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", 32'(quot), 0);
    chk("rst_rem", 32'(rem), 0);
    chk("rst_dz", 32'(dz), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned 7/2 with busy tracked through the run
    launch_exp(8'd7, 8'd2, 1'b0, 8'd3, 8'd1, 1'b0);
    repeat (8) begin
      chk("busy_run", 32'(busy), 1);
      @(posedge clk); #1;
    end
    wait_drain(20);

    launch_exp(8'd200, 8'd7, 1'b0, 8'd28, 8'd4, 1'b0);
    wait_drain(20);

    launch_exp(8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0);
    wait_drain(20);

    launch_exp(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0);
    wait_drain(20);

    // Divide by zero, then a normal op clears the flag
    launch_exp(8'd5, 8'd0, 1'b0, 8'hFF, 8'h05, 1'b1);
    chk("busy_dz", 32'(busy), 1);
    wait_drain(20);
    launch_exp(8'd9, 8'd3, 1'b0, 8'd3, 8'd0, 1'b0);
    wait_drain(20);

    // start held high with changing operands during the run is ignored
    launch_exp(8'd20, 8'd3, 1'b0, 8'd6, 8'd2, 1'b0);
    start = 1'b1; x = 8'd100; y = 8'd9; mode = 1'b1;
    repeat (8) begin
      chk("busy_hold", 32'(busy), 1);
      @(posedge clk); #1;
    end
    start = 1'b0;
    wait_drain(20);

    // Back-to-back: second start issued in the done cycle
    launch_exp(8'd100, 8'd10, 1'b0, 8'd10, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (done === 1'b1) break;
      @(posedge clk); #1;
    end
    chk("b2b_first_done", 32'(done), 1);
    launch_exp(8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0);
    chk("b2b_no_bubble", 32'(busy), 1);
    wait_drain(20);

    // Reset during the run aborts without a done pulse
    launch_exp(8'd7, 8'd2, 1'b0, 8'd3, 8'd1, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    chk("abort_quot", 32'(quot), 0);
    chk("abort_rem", 32'(rem), 0);
    chk("abort_dz", 32'(dz), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    repeat (12) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", 32'(done), 0);
    end

    // Randomised operands checked against the arithmetic model
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = (i == 4) ? 8'd0 : 8'($urandom_range(1, 255));
      rm = 1'($urandom_range(0, 1));
      launch(ra, rb, rm, model(ra, rb, rm));
      wait_drain(20);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
